cam_fb_writer: RTL and testbench

Camera-side frame-buffer writer: samples an OV7670-style 8-bit parallel pixel stream (VSYNC/HREF/DATA), packs byte pairs into RGB565 words, and issues single-cycle writes into the 320x240 frame buffer. It sits upstream of the frame buffer, opposite the VGA read path, which fetches the same words at address y*320+x. The write address layout matches that read path exactly.

---
 rtl/cam_fb_writer_if.sv | 25 ++
 rtl/cam_fb_writer.sv | 150 +++++++++++++++
 tb/tb_cam_fb_writer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_fb_writer_if.sv
// Camera pixel bus plus frame-buffer write port; master drives the camera side.
// No backpressure: the camera stream and write strobe are free-running.
interface cam_fb_writer_if #(
  parameter int ADDR_W = 17
);
  logic              capture_en;
  logic              vsync;
  logic              href;
  logic [7:0]        data;
  logic              we;
  logic [ADDR_W-1:0] wAddr;
  logic [15:0]       wData;
  logic              frame_done;
  logic              busy;

  modport master (
    output capture_en, vsync, href, data,
    input  we, wAddr, wData, frame_done, busy
  );

  modport slave (
    input  capture_en, vsync, href, data,
    output we, wAddr, wData, frame_done, busy
  );
endinterface

// File: rtl/cam_fb_writer.sv
// Packs OV7670 byte pairs into RGB565 and writes them at y*H_RES+x; write is 2 cycles after the 2nd byte.
// No backpressure: the frame buffer accepts one write per cycle, so the camera stream is never stalled.
module cam_fb_writer #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = 17
) (
  input  logic         clk,
  input  logic         reset_n,
  cam_fb_writer_if.slave cam
);

  localparam int XW = $clog2(H_RES + 1);
  localparam int YW = $clog2(V_RES + 1);
  localparam logic [XW-1:0]     X_MAX = XW'(H_RES);
  localparam logic [YW-1:0]     Y_MAX = YW'(V_RES);
  localparam logic [ADDR_W-1:0] PITCH = ADDR_W'(H_RES);

  typedef enum logic {WAIT_VS, CAPTURE} state_t;

  state_t state, state_n;

  logic       vsync_q, href_q, vsync_p, href_p;
  logic [7:0] data_q;

  logic [XW-1:0]     x, x_n;
  logic [YW-1:0]     line, line_n;
  logic [ADDR_W-1:0] line_base, line_base_n;
  logic              phase, phase_n;
  logic [7:0]        hi, hi_n;

  logic              we_r, we_n;
  logic [ADDR_W-1:0] waddr_r, waddr_n;
  logic [15:0]       wdata_r, wdata_n;
  logic              fdone_r, fdone_n;

  logic vs_fall, vs_rise, href_fall;

  assign vs_fall   = vsync_p & ~vsync_q;
  assign vs_rise   = ~vsync_p & vsync_q;
  assign href_fall = href_p & ~href_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= 8'd0;
      vsync_p <= 1'b0;
      href_p  <= 1'b0;
    end else begin
      vsync_q <= cam.vsync;
      href_q  <= cam.href;
      data_q  <= cam.data;
      vsync_p <= vsync_q;
      href_p  <= href_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= WAIT_VS;
    else          state <= state_n;
  end

  always_comb begin
    state_n     = state;
    x_n         = x;
    line_n      = line;
    line_base_n = line_base;
    phase_n     = phase;
    hi_n        = hi;
    we_n        = 1'b0;
    waddr_n     = waddr_r;
    wdata_n     = wdata_r;
    fdone_n     = 1'b0;

    case (state)
      WAIT_VS: begin
        if (vs_fall && cam.capture_en) begin
          x_n         = '0;
          line_n      = '0;
          line_base_n = '0;
          phase_n     = 1'b0;
          state_n     = CAPTURE;
        end
      end
      CAPTURE: begin
        // Frame end takes priority over any line bookkeeping in the same cycle.
        if (vs_rise) begin
          fdone_n = 1'b1;
          state_n = WAIT_VS;
        end else if (href_fall) begin
          // Clipped lines (line == V_RES) must not push line_base past the last row.
          if (x != '0 && line < Y_MAX) begin
            line_base_n = line_base + PITCH;
            line_n      = line + YW'(1);
          end
          x_n     = '0;
          phase_n = 1'b0;
        end else if (href_q) begin
          if (!phase) begin
            hi_n    = data_q;
            phase_n = 1'b1;
          end else begin
            phase_n = 1'b0;
            if (x < X_MAX && line < Y_MAX) begin
              we_n    = 1'b1;
              waddr_n = line_base + ADDR_W'(x);
              wdata_n = {hi, data_q};
              x_n     = x + XW'(1);
            end else begin
              x_n = X_MAX;
            end
          end
        end
      end
      default: state_n = WAIT_VS;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x         <= '0;
      line      <= '0;
      line_base <= '0;
      phase     <= 1'b0;
      hi        <= 8'd0;
      we_r      <= 1'b0;
      waddr_r   <= '0;
      wdata_r   <= 16'd0;
      fdone_r   <= 1'b0;
    end else begin
      x         <= x_n;
      line      <= line_n;
      line_base <= line_base_n;
      phase     <= phase_n;
      hi        <= hi_n;
      we_r      <= we_n;
      waddr_r   <= waddr_n;
      wdata_r   <= wdata_n;
      fdone_r   <= fdone_n;
    end
  end

  assign cam.we         = we_r;
  assign cam.wAddr      = waddr_r;
  assign cam.wData      = wdata_r;
  assign cam.frame_done = fdone_r;
  assign cam.busy       = (state == CAPTURE);

endmodule

// File: tb/tb_cam_fb_writer.sv
// Directed bench for cam_fb_writer on a scaled 16x8 frame; a negedge monitor tallies writes and frame_done.
module tb_cam_fb_writer;

  localparam int H = 16;
  localparam int V = 8;
  localparam int N = H * V;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  cam_fb_writer_if #(.ADDR_W(17)) cam ();

  cam_fb_writer #(.H_RES(H), .V_RES(V), .ADDR_W(17)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cam     (cam)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic        mon_clr = 1'b0;
  logic [15:0] exp_dat = 16'h0000;
  int          wr_cnt, fd_cnt, order_err, bad_dat, oob;
  logic [16:0] first_addr, last_addr, max_addr;
  bit          wr_map [0:N-1];
  logic [15:0] dat_map [0:N-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_clr) begin
      wr_cnt = 0; fd_cnt = 0; order_err = 0; bad_dat = 0; oob = 0;
      first_addr = '0; last_addr = '0; max_addr = '0;
      for (int i = 0; i < N; i++) begin
        wr_map[i]  = 1'b0;
        dat_map[i] = 16'h0;
      end
    end else begin
      if (cam.we) begin
        if (wr_cnt == 0) first_addr = cam.wAddr;
        else if (cam.wAddr <= last_addr) order_err++;
        last_addr = cam.wAddr;
        if (cam.wAddr > max_addr) max_addr = cam.wAddr;
        if (int'(cam.wAddr) < N) begin
          wr_map[int'(cam.wAddr)]  = 1'b1;
          dat_map[int'(cam.wAddr)] = cam.wData;
        end else oob++;
        if (cam.wData != exp_dat) bad_dat++;
        wr_cnt++;
      end
      if (cam.frame_done) fd_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic frame_start();
    cam.href  = 1'b0;
    cam.vsync = 1'b1;
    repeat (3) tick();
    cam.vsync = 1'b0;
    repeat (4) tick();
  endtask

  task automatic frame_end();
    cam.href  = 1'b0;
    cam.vsync = 1'b1;
    repeat (4) tick();
  endtask

  task automatic send_line(input int nbytes, input logic [7:0] b0, input logic [7:0] b1);
    for (int i = 0; i < nbytes; i++) begin
      cam.href = 1'b1;
      cam.data = (i % 2 == 1) ? b1 : b0;
      tick();
    end
    cam.href = 1'b0;
    cam.data = 8'h00;
    repeat (4) tick();
  endtask

  function automatic int cnt_range(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (wr_map[i]) c++;
    return c;
  endfunction

  initial begin
    bit hit;
    cam.capture_en = 1'b0;
    cam.vsync      = 1'b1;
    cam.href       = 1'b0;
    cam.data       = 8'h00;
    mon_clr        = 1'b1;
    repeat (3) tick();
    check("rst_we",    32'(cam.we), 0);
    check("rst_waddr", 32'(cam.wAddr), 0);
    check("rst_wdata", 32'(cam.wData), 0);
    check("rst_fdone", 32'(cam.frame_done), 0);
    check("rst_busy",  32'(cam.busy), 0);
    reset_n = 1'b1;
    repeat (2) tick();
    mon_clr = 1'b0;

    // Full frame with first-pixel and frame-end timing probes
    cam.capture_en = 1'b1;
    exp_dat = 16'hABCD;
    clear_mon();
    cam.vsync = 1'b1;
    repeat (3) tick();
    cam.vsync = 1'b0;
    tick();
    check("busy_pre", 32'(cam.busy), 0);
    tick();
    check("busy_rise", 32'(cam.busy), 1);
    repeat (2) tick();
    cam.href = 1'b1; cam.data = 8'hAB; tick();
    cam.data = 8'hCD; tick();
    check("we_lat1", 32'(cam.we), 0);
    cam.data = 8'hAB; tick();
    check("we_lat2",   32'(cam.we), 1);
    check("px0_addr",  32'(cam.wAddr), 0);
    check("px0_data",  32'(cam.wData), 32'h0000ABCD);
    cam.data = 8'hCD; tick();
    check("we_pulse", 32'(cam.we), 0);
    for (int i = 4; i < 2 * H; i++) begin
      cam.data = (i % 2 == 1) ? 8'hCD : 8'hAB;
      tick();
    end
    cam.href = 1'b0;
    repeat (4) tick();
    for (int l = 1; l < V; l++) send_line(2 * H, 8'hAB, 8'hCD);
    cam.vsync = 1'b1; tick();
    check("fd_pre", 32'(cam.frame_done), 0);
    tick();
    check("fd_pulse", 32'(cam.frame_done), 1);
    check("busy_fall", 32'(cam.busy), 0);
    tick();
    check("fd_one", 32'(cam.frame_done), 0);
    check("full_cnt",   wr_cnt, N);
    check("full_first", 32'(first_addr), 0);
    check("full_last",  32'(last_addr), N - 1);
    check("full_order", order_err, 0);
    check("full_data",  bad_dat, 0);
    check("full_fd",    fd_cnt, 1);

    // Short first line
    exp_dat = 16'h1122;
    clear_mon();
    frame_start();
    send_line(20, 8'h11, 8'h22);
    for (int l = 1; l < V; l++) send_line(2 * H, 8'h11, 8'h22);
    frame_end();
    check("short_cnt",  wr_cnt, 10 + (V - 1) * H);
    check("short_gap",  cnt_range(10, H - 1), 0);
    check("short_x9",   32'(wr_map[9]), 1);
    check("short_l1",   32'(wr_map[H]), 1);
    check("short_last", 32'(last_addr), N - 1);
    check("short_data", bad_dat, 0);

    // Overlong lines and extra lines are clipped
    exp_dat = 16'h3C5A;
    clear_mon();
    frame_start();
    for (int l = 0; l < V + 2; l++) send_line(2 * (H + 6), 8'h3C, 8'h5A);
    frame_end();
    check("clip_cnt",   wr_cnt, N);
    check("clip_max",   32'(max_addr), N - 1);
    check("clip_oob",   oob, 0);
    check("clip_order", order_err, 0);
    check("clip_fd",    fd_cnt, 1);

    // Odd byte count leaves no skew on the next line
    clear_mon();
    frame_start();
    send_line(2 * H + 1, 8'h10, 8'h20);
    send_line(2 * H, 8'h55, 8'h66);
    frame_end();
    check("odd_l0",   cnt_range(0, H - 1), H);
    check("odd_l0e",  32'(dat_map[H - 1]), 32'h1020);
    check("odd_l1s",  32'(dat_map[H]), 32'h5566);
    check("odd_l1e",  32'(dat_map[2 * H - 1]), 32'h5566);
    check("odd_cnt",  wr_cnt, 2 * H);

    // capture_en gating is evaluated only at the frame start
    exp_dat = 16'h7788;
    cam.capture_en = 1'b0;
    clear_mon();
    frame_start();
    check("dis_busy", 32'(cam.busy), 0);
    send_line(2 * H, 8'h77, 8'h88);
    cam.capture_en = 1'b1;
    send_line(2 * H, 8'h77, 8'h88);
    frame_end();
    check("dis_cnt", wr_cnt, 0);
    check("dis_fd",  fd_cnt, 0);
    frame_start();
    send_line(2 * H, 8'h77, 8'h88);
    cam.capture_en = 1'b0;
    send_line(2 * H, 8'h77, 8'h88);
    frame_end();
    check("drop_cnt", wr_cnt, 2 * H);
    check("drop_fd",  fd_cnt, 1);
    frame_start();
    send_line(2 * H, 8'h77, 8'h88);
    frame_end();
    check("next_cnt", wr_cnt, 2 * H);
    check("next_fd",  fd_cnt, 1);

    // Asynchronous reset mid-frame
    cam.capture_en = 1'b1;
    clear_mon();
    frame_start();
    send_line(2 * H, 8'h77, 8'h88);
    send_line(2 * H, 8'h77, 8'h88);
    hit = 1'b0;
    for (int i = 0; i < 2 * H && !hit; i++) begin
      cam.href = 1'b1;
      cam.data = (i % 2 == 1) ? 8'h88 : 8'h77;
      tick();
      if (cam.we && cam.wAddr == 17'(2 * H + 4)) hit = 1'b1;
    end
    check("rst_hit", 32'(hit), 1);
    reset_n = 1'b0;
    #1;
    check("arst_we",    32'(cam.we), 0);
    check("arst_waddr", 32'(cam.wAddr), 0);
    check("arst_wdata", 32'(cam.wData), 0);
    check("arst_busy",  32'(cam.busy), 0);
    repeat (2) tick();
    reset_n = 1'b1;
    clear_mon();
    send_line(10, 8'h77, 8'h88);
    frame_end();
    check("arst_nowr", wr_cnt, 0);
    check("arst_nofd", fd_cnt, 0);
    frame_start();
    send_line(2 * H, 8'h77, 8'h88);
    frame_end();
    check("resume_first", 32'(first_addr), 0);
    check("resume_cnt",   wr_cnt, H);
    check("resume_fd",    fd_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
